// File: rtl/eqy_miter_monitor.sv
// ---------------------------------------------------------------------------
// eqy_miter_monitor
//
// Clocked gold-vs-gate equivalence monitor for partitioned netlists. It
// compares CHANNELS buses of WIDTH bits every cycle. Gold, care and en are
// delayed by GATE_LAT cycles so that they line up with the slower gate side.
// Care bits mask individual bits out of the comparison; a masked bit is how
// an X on gold is expressed.
//
// Sample handshake: en is a valid-only strobe. There is no ready, because the
// monitor accepts one sample every cycle. A sample is compared only when its
// delayed copy of en arrives at the end of the alignment chain. clr and rst
// cancel samples that are still in flight.
//
// Ports
//   clk          sampling clock
//   rst          asynchronous, active-low reset
//   en           gold/care sample valid this cycle
//   clr          synchronous clear of stats, capture and alignment chain
//   gold/gate    CHANNELS*WIDTH buses, channel c at [c*WIDTH +: WIDTH]
//   care         1 = bit compared, 0 = don't-care
//   mismatch     per-channel mismatch of the last compared sample
//   fail         sticky failure flag
//   mis_cnt      saturating count of samples with any channel mismatching
//   cmp_cnt      saturating count of compared samples
//   first_valid  first-failure capture is valid
//   first_ch     lowest failing channel of the first failing sample
//   first_cyc    cmp_cnt value (0-based sample index) of the first failure
//   first_diff   (gold^gate)&care of first_ch at the first failure
//   dbg_state    FSM state (0 EMPTY, 1 RUN, 2 FAILED)
// ---------------------------------------------------------------------------
module eqy_miter_monitor #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int GATE_LAT = 0,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic [CHANNELS*WIDTH-1:0]   gold,
    input  logic [CHANNELS*WIDTH-1:0]   gate,
    input  logic [CHANNELS*WIDTH-1:0]   care,
    output logic [CHANNELS-1:0]         mismatch,
    output logic                        fail,
    output logic [CNT_W-1:0]            mis_cnt,
    output logic [CNT_W-1:0]            cmp_cnt,
    output logic                        first_valid,
    output logic [CH_W-1:0]             first_ch,
    output logic [CNT_W-1:0]            first_cyc,
    output logic [WIDTH-1:0]            first_diff,
    output logic [1:0]                  dbg_state
);

    localparam int N = CHANNELS * WIDTH;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FAILED = 2'd2;

    // ------------------------------------------------------------------
    // Alignment chain: gold/care/en delayed by GATE_LAT; gate is used live.
    // ------------------------------------------------------------------
    logic         al_vld;
    logic [N-1:0] al_gold;
    logic [N-1:0] al_care;

    if (GATE_LAT == 0) begin : g_nolat
        assign al_vld  = en & ~clr;
        assign al_gold = gold;
        assign al_care = care;
    end else begin : g_lat
        logic [GATE_LAT-1:0] vld_q;
        logic [N-1:0]        gold_q [GATE_LAT];
        logic [N-1:0]        care_q [GATE_LAT];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= '0;
                for (int i = 0; i < GATE_LAT; i++) begin
                    gold_q[i] <= '0;
                    care_q[i] <= '0;
                end
            end else begin
                // Only the valid bits are flushed by clr; the data is
                // ignored while its valid bit is low.
                vld_q[0]  <= en & ~clr;
                gold_q[0] <= gold;
                care_q[0] <= care;
                for (int i = 1; i < GATE_LAT; i++) begin
                    vld_q[i]  <= vld_q[i-1] & ~clr;
                    gold_q[i] <= gold_q[i-1];
                    care_q[i] <= care_q[i-1];
                end
            end
        end

        assign al_vld  = vld_q[GATE_LAT-1];
        assign al_gold = gold_q[GATE_LAT-1];
        assign al_care = care_q[GATE_LAT-1];
    end

    // ------------------------------------------------------------------
    // Per-channel compare and lowest-index failing channel.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    diff [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic                any_hit;
    logic [CH_W-1:0]     lo_ch;
    logic [WIDTH-1:0]    lo_diff;

    always_comb begin
        hit     = '0;
        lo_ch   = '0;
        lo_diff = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            diff[c] = (al_gold[c*WIDTH +: WIDTH] ^ gate[c*WIDTH +: WIDTH])
                      & al_care[c*WIDTH +: WIDTH];
            hit[c]  = |diff[c];
        end
        // Walk downwards so the lowest failing index is the one that sticks.
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (hit[c]) begin
                lo_ch   = CH_W'(c);
                lo_diff = diff[c];
            end
        end
    end

    assign any_hit = |hit;

    // ------------------------------------------------------------------
    // Registered statistics, capture and FSM.
    // ------------------------------------------------------------------
    logic [1:0]          state_q,    state_d;
    logic [CHANNELS-1:0] mismatch_q, mismatch_d;
    logic                fail_q,     fail_d;
    logic [CNT_W-1:0]    mis_cnt_q,  mis_cnt_d;
    logic [CNT_W-1:0]    cmp_cnt_q,  cmp_cnt_d;
    logic                fv_q,       fv_d;
    logic [CH_W-1:0]     fch_q,      fch_d;
    logic [CNT_W-1:0]    fcyc_q,     fcyc_d;
    logic [WIDTH-1:0]    fdiff_q,    fdiff_d;

    always_comb begin
        state_d    = state_q;
        mismatch_d = mismatch_q;
        fail_d     = fail_q;
        mis_cnt_d  = mis_cnt_q;
        cmp_cnt_d  = cmp_cnt_q;
        fv_d       = fv_q;
        fch_d      = fch_q;
        fcyc_d     = fcyc_q;
        fdiff_d    = fdiff_q;

        if (clr) begin
            state_d    = ST_EMPTY;
            mismatch_d = '0;
            fail_d     = 1'b0;
            mis_cnt_d  = '0;
            cmp_cnt_d  = '0;
            fv_d       = 1'b0;
            fch_d      = '0;
            fcyc_d     = '0;
            fdiff_d    = '0;
        end else if (al_vld) begin
            mismatch_d = hit;
            if (!(&cmp_cnt_q)) cmp_cnt_d = cmp_cnt_q + CNT_W'(1);
            if (any_hit && !(&mis_cnt_q)) mis_cnt_d = mis_cnt_q + CNT_W'(1);

            case (state_q)
                ST_EMPTY: state_d = any_hit ? ST_FAILED : ST_RUN;
                ST_RUN:   state_d = any_hit ? ST_FAILED : ST_RUN;
                default:  state_d = ST_FAILED;
            endcase

            // Capture only on the transition into FAILED; frozen afterwards.
            if (any_hit && state_q != ST_FAILED) begin
                fail_d  = 1'b1;
                fv_d    = 1'b1;
                fch_d   = lo_ch;
                fcyc_d  = cmp_cnt_q;
                fdiff_d = lo_diff;
            end
        end else begin
            mismatch_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            mismatch_q <= '0;
            fail_q     <= 1'b0;
            mis_cnt_q  <= '0;
            cmp_cnt_q  <= '0;
            fv_q       <= 1'b0;
            fch_q      <= '0;
            fcyc_q     <= '0;
            fdiff_q    <= '0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            fail_q     <= fail_d;
            mis_cnt_q  <= mis_cnt_d;
            cmp_cnt_q  <= cmp_cnt_d;
            fv_q       <= fv_d;
            fch_q      <= fch_d;
            fcyc_q     <= fcyc_d;
            fdiff_q    <= fdiff_d;
        end
    end

    assign mismatch    = mismatch_q;
    assign fail        = fail_q;
    assign mis_cnt     = mis_cnt_q;
    assign cmp_cnt     = cmp_cnt_q;
    assign first_valid = fv_q;
    assign first_ch    = fch_q;
    assign first_cyc   = fcyc_q;
    assign first_diff  = fdiff_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/eqy_miter_monitor.md
Name: eqy_miter_monitor

Overview:
- Parametrised, clocked successor to the per-net equivalence miter, for simulation-side gold-vs-gate checking of partitioned netlists (e.g. aes_cipher_top buffer partitions).
- Compares CHANNELS output buses of WIDTH bits each, cycle by cycle.
- Aligns gold to gate for a fixed gate pipeline latency, and supports per-bit don't-care masking; a masked bit stands in for an X on gold.
- Reports per-channel mismatch, a sticky fail flag, saturating statistics and a capture of the first failure.

Parameters:
- WIDTH, 1, bits per channel.
- CHANNELS, 4, number of compared channels.
- GATE_LAT, 0, cycles by which gate lags gold (0..15); gold, care and en are delayed by this amount.
- CNT_W, 16, width of the statistics counters and the cycle stamp.

Ports:
- clk  in  1  sampling clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  gold/care sample valid this cycle.
- clr  in  1  synchronous clear of statistics, capture and alignment pipeline.
- gold  in  CHANNELS*WIDTH  golden outputs; channel c occupies bits [c*WIDTH +: WIDTH].
- gate  in  CHANNELS*WIDTH  gate outputs, same packing.
- care  in  CHANNELS*WIDTH  1 = bit compared, 0 = don't-care.
- mismatch  out  CHANNELS  per-channel mismatch of the last compared sample.
- fail  out  1  sticky; set on any mismatch.
- mis_cnt  out  CNT_W  count of compared samples with ≥1 channel mismatching; saturates.
- cmp_cnt  out  CNT_W  count of compared samples; saturates.
- first_valid  out  1  first-failure capture is valid.
- first_ch  out  max(1,$clog2(CHANNELS))  lowest failing channel index at the first failure.
- first_cyc  out  CNT_W  cmp_cnt value at the first failing sample (its 0-based index).
- first_diff  out  WIDTH  (gold^gate)&care of first_ch at the first failure.

Behaviour:
- Reset (rst=0, async): all outputs 0, alignment pipeline emptied, FSM in EMPTY.
- Alignment: en, gold and care pass through a GATE_LAT-stage register chain; gate is taken live. The aligned valid bit resets to 0, so no compare happens during pipeline fill. With GATE_LAT=0 the chain is a wire.
- Compare (aligned valid=1), per channel c: diff_c = (gold_d^gate)&care_d; hit_c = |diff_c.
- Registered update one cycle after the aligned sample:
  - mismatch <= hit.
  - cmp_cnt += 1.
  - mis_cnt += 1 if any hit_c.
  - Both counters hold at all-ones once saturated.
- Aligned valid=0: mismatch <= 0; counters and capture hold.
- FSM states:
  - EMPTY: no compares yet. First aligned valid → RUN, or FAILED if it mismatches.
  - RUN: aligned valid with any hit → FAILED.
  - FAILED: absorbing until clr or rst. Counters and mismatch keep updating. Capture fields are frozen.
- Entry to FAILED loads first_valid=1, first_ch, first_cyc and first_diff, and sets fail=1.
- When several channels fail in the same sample, the lowest index is captured.
- clr=1 (sync, highest priority):
  - Clears counters, mismatch, fail and capture; FSM → EMPTY.
  - Empties the alignment chain (valid bits only).
  - The en sample in the same cycle is discarded.
- Mid-operation reset: identical to power-up; no state retained.
- A sample whose care bits are all 0 counts in cmp_cnt and never mismatches.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- CHANNELS=4, WIDTH=1, GATE_LAT=0, care=all 1s, gate=gold for 10 en cycles → cmp_cnt=10, mis_cnt=0, fail=0, first_valid=0.
- At sample 5, gate ch2 ≠ gold; additionally at sample 7, ch0 and ch3 mismatch → at sample 5 capture first_ch=2, first_cyc=5, first_diff=1 and set fail=1. At sample 7 mismatch=4'b1001, mis_cnt=2, capture unchanged.
- Mismatching bit with care=0 on that bit → mismatch=0 and fail=0 throughout.
- GATE_LAT=3, gate = gold delayed 3 cycles → no fail. First compare occurs 3 cycles after the first en; cmp_cnt lags en count by 3.
- CNT_W=4, 20 mismatching samples → mis_cnt=15 and cmp_cnt=15; both hold at 15.
- clr asserted together with en on a mismatching sample → that sample is ignored; all outputs are 0 next cycle. Then rst pulsed low mid-stream → outputs 0 immediately (async), and compares resume only after GATE_LAT refill.
